// File: rtl/sound_ddr_feeder.sv
// sound_ddr_feeder: fetches a block of 16-bit PCM samples from DDR in
// bursts of 64-bit words and unpacks each word onto the four write lanes
// of the sound buffer.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for sound_start
// ARM    | waiting for buffer free-space (sound_write_ready)
// REQ    | burst request presented, held until DDR accepts it
// DATA   | receiving burst beats, one registered lane write per beat
// FINISH | one-cycle sound_done pulse

module sound_ddr_feeder #(
    parameter int ADDR_W          = 29,
    parameter int LEN_W           = 20,
    parameter int MAX_BURST_WORDS = 128
) (
    input  logic              clk_sys,
    input  logic              sound_reset_n,
    input  logic              sound_start,
    input  logic [ADDR_W-1:0] sound_base,
    input  logic [LEN_W-1:0]  sound_len,
    input  logic              sound_write_ready,
    input  logic              ddr_busy,
    output logic              ddr_rd,
    output logic [ADDR_W-1:0] ddr_addr,
    output logic [7:0]        ddr_burstcnt,
    input  logic [63:0]       ddr_dout,
    input  logic              ddr_dout_ready,
    output logic              sound_wren1,
    output logic              sound_wren2,
    output logic              sound_wren3,
    output logic              sound_wren4,
    output logic [15:0]       sound_in1,
    output logic [15:0]       sound_in2,
    output logic [15:0]       sound_in3,
    output logic [15:0]       sound_in4,
    output logic              sound_busy,
    output logic              sound_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_REQ,
        S_DATA,
        S_FINISH
    } state_t;

    localparam logic [7:0]       MAX_BURST   = 8'(MAX_BURST_WORDS);
    localparam logic [LEN_W-1:0] MAX_BURST_L = LEN_W'(MAX_BURST_WORDS);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    samples_left_q, samples_left_d;
    logic [LEN_W-1:0]    words_left_q, words_left_d;
    logic [7:0]          beats_left_q, beats_left_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   ddr_addr_q, ddr_addr_d;
    logic [7:0]          burstcnt_q, burstcnt_d;
    logic [3:0]          wren_q, wren_d;
    logic [63:0]         lanes_q, lanes_d;

    logic [LEN_W:0]      len_plus3;
    logic [LEN_W-1:0]    words_init;
    logic [7:0]          burst_next;
    logic [3:0]          lane_mask;
    logic [2:0]          take_cnt;

    // Word count is ceil(len/4); the extra bit keeps len+3 from overflowing.
    assign len_plus3  = {1'b0, sound_len} + (LEN_W+1)'(3);
    assign words_init = {1'b0, len_plus3[LEN_W:2]};

    assign burst_next = (words_left_q > MAX_BURST_L) ? MAX_BURST : words_left_q[7:0];

    // Lane enables form a prefix sized by the samples still owed.
    assign lane_mask[0] = (samples_left_q > LEN_W'(0));
    assign lane_mask[1] = (samples_left_q > LEN_W'(1));
    assign lane_mask[2] = (samples_left_q > LEN_W'(2));
    assign lane_mask[3] = (samples_left_q > LEN_W'(3));
    assign take_cnt     = (samples_left_q >= LEN_W'(4)) ? 3'd4 : samples_left_q[2:0];

    // Next-state and datapath update for every register in the block.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        samples_left_d = samples_left_q;
        words_left_d   = words_left_q;
        beats_left_d   = beats_left_q;
        rd_d           = rd_q;
        ddr_addr_d     = ddr_addr_q;
        burstcnt_d     = burstcnt_q;
        wren_d         = 4'b0000;
        lanes_d        = lanes_q;

        case (state_q)
            S_IDLE: begin
                if (sound_start) begin
                    addr_d         = sound_base;
                    samples_left_d = sound_len;
                    words_left_d   = words_init;
                    state_d        = (sound_len == '0) ? S_FINISH : S_ARM;
                end
            end

            S_ARM: begin
                if (sound_write_ready) begin
                    burstcnt_d = burst_next;
                    ddr_addr_d = addr_q;
                    rd_d       = 1'b1;
                    state_d    = S_REQ;
                end
            end

            S_REQ: begin
                if (!ddr_busy) begin
                    rd_d         = 1'b0;
                    beats_left_d = burstcnt_q;
                    state_d      = S_DATA;
                end
            end

            S_DATA: begin
                if (ddr_dout_ready) begin
                    wren_d = lane_mask;
                    for (int i = 0; i < 4; i++) begin
                        if (lane_mask[i]) begin
                            lanes_d[16*i +: 16] = ddr_dout[16*i +: 16];
                        end
                    end
                    samples_left_d = samples_left_q - {{(LEN_W-3){1'b0}}, take_cnt};
                    beats_left_d   = beats_left_q - 8'd1;
                    words_left_d   = words_left_q - LEN_W'(1);
                    if (beats_left_q == 8'd1) begin
                        addr_d  = addr_q + {{(ADDR_W-8){1'b0}}, burstcnt_q};
                        state_d = (words_left_q == LEN_W'(1)) ? S_FINISH : S_ARM;
                    end
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk_sys or negedge sound_reset_n) begin
        if (!sound_reset_n) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            samples_left_q <= '0;
            words_left_q   <= '0;
            beats_left_q   <= '0;
            rd_q           <= 1'b0;
            ddr_addr_q     <= '0;
            burstcnt_q     <= '0;
            wren_q         <= '0;
            lanes_q        <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            samples_left_q <= samples_left_d;
            words_left_q   <= words_left_d;
            beats_left_q   <= beats_left_d;
            rd_q           <= rd_d;
            ddr_addr_q     <= ddr_addr_d;
            burstcnt_q     <= burstcnt_d;
            wren_q         <= wren_d;
            lanes_q        <= lanes_d;
        end
    end

    assign ddr_rd       = rd_q;
    assign ddr_addr     = ddr_addr_q;
    assign ddr_burstcnt = burstcnt_q;

    assign sound_wren1  = wren_q[0];
    assign sound_wren2  = wren_q[1];
    assign sound_wren3  = wren_q[2];
    assign sound_wren4  = wren_q[3];
    assign sound_in1    = lanes_q[15:0];
    assign sound_in2    = lanes_q[31:16];
    assign sound_in3    = lanes_q[47:32];
    assign sound_in4    = lanes_q[63:48];

    assign sound_busy   = (state_q != S_IDLE);
    assign sound_done   = (state_q == S_FINISH);

endmodule
